sine_gen: RTL and testbench
===========================

SINE_GEN -- requirements
Module: sine_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: sine table address width; the table holds 2^ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32: sample width, two's complement.
REQ-003 Parameter INIT_ADDR, default 0 (ADDR_WIDTH bits): table address reloaded on reset.
REQ-004 Parameter FRAC_WIDTH, default 0: fractional phase bits below the table address; FRAC_WIDTH+ADDR_WIDTH SHALL be <= 31.
REQ-005 Parameter FILE_PATH, default "sine_data.mif": Intel MIF file holding the table contents.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 step  input  31  unsigned phase increment per clock, unsigned; sampled every cycle.
REQ-009 sine_wav  output  DATA_WIDTH  current sine sample, registered.

Function
REQ-010 Hold a 31-bit phase accumulator acc; every non-reset cycle acc <= acc + step, modulo 2^31 (carry out discarded).
REQ-011 Table address = acc[FRAC_WIDTH+ADDR_WIDTH-1 : FRAC_WIDTH]; it wraps naturally modulo 2^ADDR_WIDTH.
REQ-012 Table is a read-only synchronous memory; contents come only from FILE_PATH; no write port.
REQ-013 Base latency 1: sine_wav at edge n+1 = table[address of acc at edge n].
REQ-014 Output frequency = f_clk * step / 2^(FRAC_WIDTH+ADDR_WIDTH); step=0 holds sine_wav constant at the current table word.
REQ-015 A step change takes effect on the first accumulation after it is sampled; no glitch and no phase reset.
REQ-016 Accumulator wrap from 2^31-1 to 0 needs no special handling.

Reset
REQ-017 While rst_n=0 at a rising edge: acc <= INIT_ADDR << FRAC_WIDTH; sine_wav <= 0; every pipeline register <= 0.
REQ-018 Reset asserted mid-operation overrides accumulation in that same cycle; the output is 0 from the next edge.
REQ-019 First edge with rst_n=1: sine_wav <= table[INIT_ADDR]; acc <= INIT_ADDR<<FRAC_WIDTH + step.

Configuration
REQ-020 Macro SINE_GEN_OUT_REG_EN: when defined, one extra output register follows the table read, so latency is 2 and the register resets to 0.
REQ-021 When SINE_GEN_OUT_REG_EN is undefined, latency is 1 per REQ-013; all other behaviour is identical.

Structure
REQ-022 Package sine_gen_pkg SHALL hold the default ADDR_WIDTH, DATA_WIDTH, and PHASE_WIDTH (31) constants.
REQ-023 Sub-module sine_rom (parameters ADDR_WIDTH, DATA_WIDTH, FILE_PATH; ports clk, addr, q) SHALL implement the registered ROM.
REQ-024 sine_gen SHALL contain only the accumulator, the address slice, the optional output register, and the reset logic.

Verification (test MIF: table[i] = i, ADDR_WIDTH=12, FRAC_WIDTH=0, no macro unless stated)
REQ-025 rst_n=0 for 5 cycles, step=3 -> sine_wav=0 throughout; after release outputs are 0,3,6,9,... in order.
REQ-026 INIT_ADDR=12'h100, step=1 -> first post-reset samples are 256,257,258.
REQ-027 step=63, run 100 cycles -> address wraps past 4095 with no skip: 4032,4095,62,125 continuing mod 4096.
REQ-028 step changes 2->5 mid-run -> increment changes on the following sample; no phase jump; step=0 -> output frozen.
REQ-029 Reset reasserted mid-run -> sine_wav=0 on the next edge; after release, sequence restarts at INIT_ADDR.
REQ-030 With SINE_GEN_OUT_REG_EN defined -> the REQ-025 sequence is identical but delayed one extra cycle.

Source files
------------

// File: rtl/sine_gen_pkg.sv
// Shared constants for the sine generator: default table geometry and phase width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sine_gen_pkg;

    // Default sine table address width; the table holds 2^DEF_ADDR_WIDTH words.
    localparam int DEF_ADDR_WIDTH = 12;

    // Default sample width, two's complement.
    localparam int DEF_DATA_WIDTH = 32;

    // Width of the phase accumulator and of the step input.
    localparam int PHASE_WIDTH = 31;

endpackage : sine_gen_pkg

// File: rtl/sine_rom.sv
// Read-only sine table with a registered read port; contents come from an Intel MIF file.
// Latency: 1 cycle from addr to q.
// Backpressure: none; a new address is accepted and read on every clock.
module sine_rom
    import sine_gen_pkg::*;
#(
    parameter int    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter string FILE_PATH  = "sine_data.mif"
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // An empty path would silently produce an all-zero table.
    if (FILE_PATH == "") begin : g_no_file
        $error("sine_rom: FILE_PATH must name a MIF file");
    end

    // Table contents are loaded from FILE_PATH by the init-file attribute; there is no write port.
    (* ram_init_file = FILE_PATH *)
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1] = '{default: '0};

    // Registered read: the word at addr appears on q after the next rising edge.
    always_ff @(posedge clk) begin
        q <= r_mem[addr];
    end

endmodule : sine_rom

// File: rtl/sine_gen.sv
// Phase-accumulator sine generator (DDS) driving a registered sine table; optional output stage via SINE_GEN_OUT_REG_EN.
// Latency: 1 cycle from accumulator to sine_wav (2 with SINE_GEN_OUT_REG_EN defined).
// Backpressure: none; step is sampled and one sample is produced on every clock.
module sine_gen
    import sine_gen_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] INIT_ADDR  = '0,
    parameter int                    FRAC_WIDTH = 0,
    parameter string                 FILE_PATH  = "sine_data.mif"
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PHASE_WIDTH-1:0] step,
    output logic [DATA_WIDTH-1:0]  sine_wav
);

    // Accumulator value loaded on reset: the start address positioned above the fraction bits.
    localparam logic [PHASE_WIDTH-1:0] ACC_INIT = PHASE_WIDTH'(INIT_ADDR) << FRAC_WIDTH;

    // The table address must fit inside the accumulator.
    if (FRAC_WIDTH + ADDR_WIDTH > PHASE_WIDTH) begin : g_bad_width
        $error("sine_gen: FRAC_WIDTH + ADDR_WIDTH must not exceed PHASE_WIDTH");
    end

    logic [PHASE_WIDTH-1:0] r_acc;
    logic                   r_rd_vld;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0]  w_rom_q;
    logic [DATA_WIDTH-1:0]  w_rd_dat;
    logic                   w_unused_acc;

    // Phase accumulator wraps modulo 2^31; reset overrides accumulation in the same cycle.
    // r_rd_vld marks that the ROM word now on w_rom_q was read outside reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= ACC_INIT;
            r_rd_vld <= 1'b0;
        end else begin
            r_acc    <= r_acc + step;
            r_rd_vld <= 1'b1;
        end
    end

    // Integer part of the phase selects the table word; higher bits wrap away naturally.
    assign w_addr = r_acc[FRAC_WIDTH +: ADDR_WIDTH];

    // Fraction bits and bits above the address only carry phase; they never reach the table.
    assign w_unused_acc = ^r_acc;

    sine_rom #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FILE_PATH  (FILE_PATH)
    ) u_rom (
        .clk  (clk),
        .addr (w_addr),
        .q    (w_rom_q)
    );

    // The ROM read register has no reset, so its word is forced to zero until a non-reset read lands.
    assign w_rd_dat = r_rd_vld ? w_rom_q : '0;

`ifdef SINE_GEN_OUT_REG_EN
    logic [DATA_WIDTH-1:0] r_out;

    // Extra output stage after the table read; clears on reset like every other pipeline register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_rd_dat;
        end
    end

    assign sine_wav = r_out;
`else
    assign sine_wav = w_rd_dat;
`endif

endmodule : sine_gen

// File: tb/tb_sine_gen.sv
// Directed bench for sine_gen with an identity table (table[i] = i) preloaded into both ROM instances.
// Latency: expectations shift by one sample when SINE_GEN_OUT_REG_EN is defined.
// Backpressure: n/a; stimulus is a fixed number of clocks per test.
module tb_sine_gen;

`ifdef SINE_GEN_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 4096;

    logic        clk;
    logic        rst0_n;
    logic        rst1_n;
    logic [30:0] step0;
    logic [30:0] step1;
    logic [31:0] wav0;
    logic [31:0] wav1;

    int n_cmp;
    int n_bad;

    sine_gen #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32),
        .INIT_ADDR  (12'h000),
        .FRAC_WIDTH (0),
        .FILE_PATH  ("sine_data.mif")
    ) dut0 (
        .clk      (clk),
        .rst_n    (rst0_n),
        .step     (step0),
        .sine_wav (wav0)
    );

    sine_gen #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32),
        .INIT_ADDR  (12'h100),
        .FRAC_WIDTH (0),
        .FILE_PATH  ("sine_data.mif")
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst1_n),
        .step     (step1),
        .sine_wav (wav1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sample k edges after reset release, for a constant step.
    function automatic logic [31:0] exp_at(input int init, input int stp, input int k);
        int idx;
        idx = k - (LAT - 1);
        if (idx < 0) return 32'd0;
        return 32'((init + idx * stp) % DEPTH);
    endfunction

    // Outputs with latency 1 for the step sequence 2,2,2,5,5,5,0,0,0,0.
    int step_tbl [10] = '{2, 2, 2, 5, 5, 5, 0, 0, 0, 0};
    int lat1_tbl [10] = '{0, 2, 4, 6, 11, 16, 21, 21, 21, 21};

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        step0  = 31'd0;
        step1  = 31'd0;

        for (int i = 0; i < DEPTH; i++) begin
            dut0.u_rom.r_mem[i] = 32'(i);
            dut1.u_rom.r_mem[i] = 32'(i);
        end

        // Held reset with step=3: output stays zero, then counts by 3 from 0.
        step0 = 31'd3;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_val($sformatf("rst_hold[%0d]", k), wav0, 32'd0);
        end
        rst0_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_val($sformatf("step3[%0d]", k), wav0, exp_at(0, 3, k));
        end

        // Non-zero start address: 256, 257, 258 after release.
        step1 = 31'd1;
        tick();
        chk_val("init_rst", wav1, 32'd0);
        rst1_n = 1'b1;
        for (int k = 0; k < 3 + LAT - 1; k++) begin
            tick();
            chk_val($sformatf("init100[%0d]", k), wav1, exp_at(256, 1, k));
        end

        // Large step wrapping past the end of the table.
        rst0_n = 1'b0;
        step0  = 31'd63;
        tick();
        chk_val("wrap_rst", wav0, 32'd0);
        rst0_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            chk_val($sformatf("wrap63[%0d]", k), wav0, exp_at(0, 63, k));
        end

        // Step change mid-run and freeze with step=0.
        rst0_n = 1'b0;
        tick();
        rst0_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step0 = 31'(step_tbl[k]);
            tick();
            chk_val($sformatf("stepchg[%0d]", k), wav0,
                    (LAT == 1) ? 32'(lat1_tbl[k]) : ((k == 0) ? 32'd0 : 32'(lat1_tbl[k - 1])));
        end

        // Reset mid-run: zero on the next edge, then restart at the start address.
        step1 = 31'd7;
        for (int k = 0; k < 4; k++) tick();
        rst1_n = 1'b0;
        tick();
        chk_val("midrst1[0]", wav1, 32'd0);
        tick();
        chk_val("midrst1[1]", wav1, 32'd0);
        rst1_n = 1'b1;
        step1  = 31'd1;
        for (int k = 0; k < 3 + LAT - 1; k++) begin
            tick();
            chk_val($sformatf("restart1[%0d]", k), wav1, exp_at(256, 1, k));
        end

        rst0_n = 1'b0;
        tick();
        chk_val("midrst0", wav0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sine_gen
